// File: rtl/csa_serial_sequencer.sv
// Serial wide adder: one 4-bit carry-select slice is stepped across the operands, one nibble per clock.
// Optional signed-overflow output V is enabled by defining CSA_SEQ_OVF_EN.

module csa4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] sum_c0;
    logic [4:0] sum_c1;

    // Both carry-in cases are precomputed, and the real carry only drives the final select.
    assign sum_c0      = {1'b0, a} + {1'b0, b};
    assign sum_c1      = {1'b0, a} + {1'b0, b} + 5'd1;
    assign {cout, s}   = cin ? sum_c1 : sum_c0;
endmodule

module csa_serial_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    output logic                 ready,
    output logic                 done,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout
`ifdef CSA_SEQ_OVF_EN
    ,output logic                V
`endif
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic [W-1:0]    s_q, s_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic [IDXW-1:0] idx_q, idx_d;
`ifdef CSA_SEQ_OVF_EN
    logic            v_q, v_d;
`endif

    logic [3:0] nib_a, nib_b, slice_s;
    logic       slice_cout;

    assign nib_a = opa_q[4*idx_q +: 4];
    assign nib_b = opb_q[4*idx_q +: 4];

    csa4 u_csa4 (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout)
    );

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through this block can infer a latch.
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef CSA_SEQ_OVF_EN
        v_d     = v_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = A;
                    opb_d   = B;
                    carry_d = Cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[4*idx_q +: 4] = slice_s;
                carry_d           = slice_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_cout;
`ifdef CSA_SEQ_OVF_EN
                    // Carry into the MSB is recovered from the top bit's sum and its operand bits.
                    v_d     = (nib_a[3] ^ nib_b[3] ^ slice_s[3]) ^ slice_cout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CSA_SEQ_OVF_EN
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef CSA_SEQ_OVF_EN
            v_q     <= v_d;
`endif
        end
    end

    assign ready = (state_q == IDLE) && !rst;
    assign done  = (state_q == DONE);
    assign S     = s_q;
    assign Cout  = cout_q;
`ifdef CSA_SEQ_OVF_EN
    assign V     = v_q;
`endif

endmodule

// File: doc/csa_serial_sequencer.md
# csa_serial_sequencer

Multi-cycle controller that adds two wide operands by stepping a single 4-bit carry-select adder slice across them, one nibble per clock. The carry is held in a register between slices. The block sits between a requesting datapath and the shared 4-bit CSA. It trades latency for area: a 4·NIBBLES-bit add costs one CSA instance plus sequencing logic. It provides a start/ready/done handshake and holds the result until the next operation.

## Interface
- NIBBLES, default 4: number of 4-bit slices. Operand width W = 4·NIBBLES. Legal range 1..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when ready=1.
- A  input  W  operand A. Captured on the accepting edge.
- B  input  W  operand B. Captured on the accepting edge.
- Cin  input  1  carry-in. Captured on the accepting edge.
- ready  output  1  high in IDLE. Low while rst is asserted.
- done  output  1  one-cycle pulse when S/Cout become valid.
- S  output  W  sum. Registered, and held until the next accept.
- Cout  output  1  carry-out of the top slice. Registered and held.
- V  output  1  signed overflow. Present only with CSA_SEQ_OVF_EN (see Configuration).

## Operation
- Internally instantiate one 4-bit CSA (A4, B4, Cin1 -> S4, Cout1). Its inputs are driven by the current nibble of the captured operands and by the carry register.
- State machine:
  - IDLE: ready=1. If start=1 at a clock edge: capture A, B → opA/opB; Cin → carry; idx ← 0; go to RUN. Otherwise stay in IDLE.
  - RUN: the CSA evaluates nibble idx combinationally. At each edge: S[4·idx+3:4·idx] ← slice sum; carry ← slice cout; idx ← idx+1. When idx = NIBBLES−1, Cout ← slice cout and go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- Arithmetic: {Cout,S} = A + B + Cin, computed modulo 2^(W+1). Operands are unsigned; no saturation.
- While in RUN or DONE, start is ignored. Input changes after capture have no effect on the result.
- S nibbles not yet written keep their previous-operation values until overwritten. Read S only when done=1 or after it.
- idx is ⌈log2 NIBBLES⌉ bits, minimum 1 bit. It never wraps past NIBBLES−1.
- Reset values: state=IDLE, S=0, Cout=0, done=0, V=0, carry=0, idx=0. ready=0 while rst=1, then 1 from the first cycle after deassertion.
- Reset asserted mid-RUN or in DONE aborts the operation. Outputs go to their reset values on that edge, and no done pulse is issued.
- If rst and start are both high on the same edge, rst wins and the request is dropped.

## Timing
- The accepting edge is edge 0.
- RUN occupies the cycles after edges 0 .. NIBBLES−1.
- done is high during the cycle after edge NIBBLES: latency NIBBLES+1 clocks from accept to done.
- ready returns high in the cycle after done. Minimum start-to-start spacing is NIBBLES+2 cycles.
- The critical path is one CSA slice plus the nibble mux. There is no W-bit carry chain.

## Configuration
- CSA_SEQ_OVF_EN defined:
  - A register V is added. It is written on the final RUN edge as carry_into_msb XOR slice cout, i.e. two's-complement overflow of A+B+Cin.
  - V resets to 0 and is held with S.
- CSA_SEQ_OVF_EN undefined:
  - No V port and no overflow logic.
  - All other behaviour is bit-identical.

## Test plan
- Exhaustive, NIBBLES=1: all 16×16×2 combinations of A, B, Cin. After each done, check {Cout,S} = A+B+Cin. Error count must be 0.
- NIBBLES=4, A=16'hFFFF, B=16'h0001, Cin=0 → S=16'h0000, Cout=1. done exactly 5 cycles after accept. ready low for those 5 cycles.
- NIBBLES=4, A=16'h1234, B=16'h4321, Cin=1 → S=16'h5556, Cout=0. Change A/B/Cin during RUN: result must be unchanged.
- NIBBLES=4: hold start=1 continuously. Accepts occur every 6 cycles. done pulses are exactly 1 cycle wide, and no request is accepted while ready=0.
- NIBBLES=4: assert rst on the 2nd RUN cycle. The next edge gives S=0, Cout=0, no done pulse, ready=1 after rst drops. A new add of 16'h0F0F+16'h00F1, Cin=0, then gives 16'h1000, Cout=0.
- With CSA_SEQ_OVF_EN, NIBBLES=4:
  - 16'h7FFF + 16'h0001, Cin=0 → V=1.
  - 16'h8000 + 16'hFFFF, Cin=0 → V=1, Cout=1.
  - 16'h0001 + 16'h0001 → V=0.
